// File: rtl/branch_pkg.sv
// Shared encodings, the prediction record and the recovery FSM states for branch_resolve.
package branch_pkg;

  localparam logic [1:0] BR_NONE     = 2'b00;
  localparam logic [1:0] BR_COND     = 2'b01;
  localparam logic [1:0] BR_DIRECT   = 2'b10;
  localparam logic [1:0] BR_INDIRECT = 2'b11;

  // Record address fields are sized for the widest supported ADDR_WIDTH; users zero-extend.
  localparam int REC_AW = 64;

  typedef struct packed {
    logic [REC_AW-1:0] fetch_pc;
    logic [REC_AW-1:0] pred_pc;
    logic              branch;
    logic              reason;
  } pred_rec_t;

  typedef enum logic {RUN, RECOVER} state_t;

endpackage

// File: rtl/pred_queue.sv
// In-order FIFO of prediction records with flush; pointers carry an extra wrap bit.
module pred_queue #(
  parameter int W     = 130,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr[AW-1:0]] <= wdata;
  end

  assign head  = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/branch_resolve.sv
// Checks queued fetch predictions against EX outcomes, trains the predictor and redirects fetch.
// Optional BRANCH_RESOLVE_STAT_EN adds saturating branch/mispredict counters.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pdVld,
  output logic                  pdRdy,
  input  logic [ADDR_WIDTH-1:0] pdFetchPC,
  input  logic [ADDR_WIDTH-1:0] pdPC,
  input  logic                  pdBranch,
  input  logic                  pdReason,
  input  logic                  exInVld,
  input  logic [ADDR_WIDTH-1:0] exInPC,
  input  logic [1:0]            exInType,
  input  logic                  exInTaken,
  input  logic [ADDR_WIDTH-1:0] exInTar,
  input  logic                  exInLast,
  output logic                  exVld,
  output logic [ADDR_WIDTH-1:0] exPC,
  output logic [ADDR_WIDTH-1:0] exPCTar,
  output logic [1:0]            exType,
  output logic                  exBranch,
  output logic                  exWrong,
  output logic                  rdVld,
  output logic [ADDR_WIDTH-1:0] rdPC,
  input  logic                  rdAck,
  output logic                  err
`ifdef BRANCH_RESOLVE_STAT_EN
  ,
  output logic [31:0]           statBranches,
  output logic [31:0]           statWrong
`endif
);

  state_t          state;
  pred_rec_t       push_rec;
  pred_rec_t       head_rec;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            flush;
  logic            chk;
  logic            is_br;
  logic            taken;
  logic            here;
  logic            wrong;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic [ADDR_WIDTH-1:0] correct_pc;
  logic            unused_rec;

  assign push_rec.fetch_pc = REC_AW'(pdFetchPC);
  assign push_rec.pred_pc  = REC_AW'(pdPC);
  assign push_rec.branch   = pdBranch;
  assign push_rec.reason   = pdReason;

  assign head_pc    = head_rec.pred_pc[ADDR_WIDTH-1:0];
  assign unused_rec = ^{head_rec.fetch_pc, head_rec.pred_pc};

  assign pdRdy = !rst && !full && (state == RUN);
  assign push  = pdVld && pdRdy;

  // A report only counts against a record when one exists; an empty queue is a protocol error.
  assign chk   = exInVld && (state == RUN) && !empty;
  assign is_br = (exInType != BR_NONE);
  assign taken = exInTaken && is_br;
  assign here  = head_rec.branch && (head_rec.reason == exInPC[2]);
  assign wrong = (taken != here) || (taken && here && (exInTar != head_pc));
  assign correct_pc = taken ? exInTar : exInPC + ADDR_WIDTH'(4);

  assign pop   = chk && (exInLast || wrong);
  assign flush = chk && wrong;

  pred_queue #(
    .W     ($bits(pred_rec_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (push_rec),
    .head  (head_rec),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      exVld    <= 1'b0;
      exWrong  <= 1'b0;
      exPC     <= '0;
      exPCTar  <= '0;
      exType   <= BR_NONE;
      exBranch <= 1'b0;
      rdVld    <= 1'b0;
      rdPC     <= '0;
      err      <= 1'b0;
    end else begin
      exVld   <= chk && is_br;
      exWrong <= chk && is_br && wrong;
      if (chk && is_br) begin
        exPC     <= exInPC;
        exPCTar  <= exInTar;
        exType   <= exInType;
        exBranch <= exInTaken;
      end
      if (exInVld && (state == RUN) && empty) err <= 1'b1;
      case (state)
        RUN: begin
          if (flush) begin
            state <= RECOVER;
            rdVld <= 1'b1;
            rdPC  <= correct_pc;
          end
        end
        RECOVER: begin
          if (rdAck) begin
            state <= RUN;
            rdVld <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef BRANCH_RESOLVE_STAT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      statBranches <= '0;
      statWrong    <= '0;
    end else begin
      if (chk && is_br) statBranches <= sat_inc(statBranches);
      if (flush)        statWrong    <= sat_inc(statWrong);
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: prediction check, redirect, fill/full, empty error, async reset.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        pdVld;
  logic        pdRdy;
  logic [31:0] pdFetchPC;
  logic [31:0] pdPC;
  logic        pdBranch;
  logic        pdReason;
  logic        exInVld;
  logic [31:0] exInPC;
  logic [1:0]  exInType;
  logic        exInTaken;
  logic [31:0] exInTar;
  logic        exInLast;
  logic        exVld;
  logic [31:0] exPC;
  logic [31:0] exPCTar;
  logic [1:0]  exType;
  logic        exBranch;
  logic        exWrong;
  logic        rdVld;
  logic [31:0] rdPC;
  logic        rdAck;
  logic        err;
`ifdef BRANCH_RESOLVE_STAT_EN
  logic [31:0] statBranches;
  logic [31:0] statWrong;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_resolve #(.ADDR_WIDTH(32), .QUEUE_DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .pdVld     (pdVld),
    .pdRdy     (pdRdy),
    .pdFetchPC (pdFetchPC),
    .pdPC      (pdPC),
    .pdBranch  (pdBranch),
    .pdReason  (pdReason),
    .exInVld   (exInVld),
    .exInPC    (exInPC),
    .exInType  (exInType),
    .exInTaken (exInTaken),
    .exInTar   (exInTar),
    .exInLast  (exInLast),
    .exVld     (exVld),
    .exPC      (exPC),
    .exPCTar   (exPCTar),
    .exType    (exType),
    .exBranch  (exBranch),
    .exWrong   (exWrong),
    .rdVld     (rdVld),
    .rdPC      (rdPC),
    .rdAck     (rdAck),
    .err       (err)
`ifdef BRANCH_RESOLVE_STAT_EN
    ,
    .statBranches (statBranches),
    .statWrong    (statWrong)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pd(input logic [31:0] fpc, input logic [31:0] ppc,
                        input logic br, input logic rs);
    pdVld     = 1'b1;
    pdFetchPC = fpc;
    pdPC      = ppc;
    pdBranch  = br;
    pdReason  = rs;
  endtask

  task automatic push(input logic [31:0] fpc, input logic [31:0] ppc,
                      input logic br, input logic rs);
    set_pd(fpc, ppc, br, rs);
    tick();
    pdVld = 1'b0;
  endtask

  task automatic set_ex(input logic [31:0] pc, input logic [1:0] typ, input logic tk,
                        input logic [31:0] tar, input logic last);
    exInVld   = 1'b1;
    exInPC    = pc;
    exInType  = typ;
    exInTaken = tk;
    exInTar   = tar;
    exInLast  = last;
  endtask

  task automatic report(input logic [31:0] pc, input logic [1:0] typ, input logic tk,
                        input logic [31:0] tar, input logic last);
    set_ex(pc, typ, tk, tar, last);
    tick();
    exInVld = 1'b0;
  endtask

  task automatic ack();
    rdAck = 1'b1;
    tick();
    rdAck = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pdVld = 1'b0; pdFetchPC = '0; pdPC = '0; pdBranch = 1'b0; pdReason = 1'b0;
    exInVld = 1'b0; exInPC = '0; exInType = 2'b00; exInTaken = 1'b0; exInTar = '0;
    exInLast = 1'b0; rdAck = 1'b0;
    tick();
    tick();
    check("rst_pdRdy", pdRdy, 0);
    check("rst_exVld", exVld, 0);
    check("rst_exWrong", exWrong, 0);
    check("rst_rdVld", rdVld, 0);
    check("rst_rdPC", rdPC, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    #1;
    check("run_pdRdy", pdRdy, 1);

    // 1: correctly predicted taken branch in slot 1
    push(32'h1000, 32'h2000, 1'b1, 1'b1);
    report(32'h1000, 2'b00, 1'b0, 32'h0, 1'b0);
    check("t1_nonbr_exVld", exVld, 0);
    report(32'h1004, 2'b01, 1'b1, 32'h2000, 1'b1);
    check("t1_exVld", exVld, 1);
    check("t1_exWrong", exWrong, 0);
    check("t1_exBranch", exBranch, 1);
    check("t1_exPC", exPC, 32'h1004);
    check("t1_exPCTar", exPCTar, 32'h2000);
    check("t1_exType", exType, 2'b01);
    check("t1_rdVld", rdVld, 0);
    tick();
    check("t1_idle_exVld", exVld, 0);

    // 2: predicted taken, resolved not taken
    push(32'h1000, 32'h2000, 1'b1, 1'b1);
    report(32'h1004, 2'b01, 1'b0, 32'h0, 1'b0);
    check("t2_exVld", exVld, 1);
    check("t2_exWrong", exWrong, 1);
    check("t2_exBranch", exBranch, 0);
    check("t2_rdVld", rdVld, 1);
    check("t2_rdPC", rdPC, 32'h1008);
    check("t2_pdRdy", pdRdy, 0);
    report(32'h1004, 2'b01, 1'b1, 32'h2000, 1'b1);
    check("t2_rec_exVld", exVld, 0);
    check("t2_rec_err", err, 0);
    tick();
    check("t2_hold_rdVld", rdVld, 1);
    check("t2_hold_rdPC", rdPC, 32'h1008);
    check("t2_hold_pdRdy", pdRdy, 0);
    ack();
    check("t2_ack_rdVld", rdVld, 0);
    check("t2_ack_pdRdy", pdRdy, 1);

    // 3: target mismatch on indirect; a same-cycle push must be flushed too
    push(32'h1000, 32'h2000, 1'b1, 1'b1);
    set_pd(32'h6000, 32'h5000, 1'b1, 1'b0);
    report(32'h1004, 2'b11, 1'b1, 32'h3000, 1'b1);
    pdVld = 1'b0;
    check("t3_exWrong", exWrong, 1);
    check("t3_exType", exType, 2'b11);
    check("t3_rdVld", rdVld, 1);
    check("t3_rdPC", rdPC, 32'h3000);
    ack();
    push(32'h7000, 32'h7008, 1'b0, 1'b0);
    report(32'h7000, 2'b01, 1'b0, 32'h0, 1'b1);
    check("t3_flushed_exWrong", exWrong, 0);
    check("t3_flushed_rdVld", rdVld, 0);
    check("t3_err", err, 0);

    // 4: fill to full; overflow attempts are dropped, including on a pop cycle
    for (int i = 0; i < 8; i++)
      push(32'h4000 + 32'(i) * 32'h10, 32'h4008 + 32'(i) * 32'h10, 1'b0, 1'b0);
    check("t4_full_pdRdy", pdRdy, 0);
    set_pd(32'h6000, 32'h5000, 1'b1, 1'b0);
    tick();
    set_ex(32'h4000, 2'b01, 1'b0, 32'h0, 1'b1);
    #1;
    check("t4_pop_same_pdRdy", pdRdy, 0);
    tick();
    exInVld = 1'b0;
    pdVld   = 1'b0;
    check("t4_pop_next_pdRdy", pdRdy, 1);
    check("t4_pop_exVld", exVld, 1);
    check("t4_pop_exWrong", exWrong, 0);
    for (int i = 1; i < 8; i++) begin
      report(32'h4000 + 32'(i) * 32'h10, 2'b01, 1'b0, 32'h0, 1'b1);
      check("t4_drain_exWrong", exWrong, 0);
      check("t4_drain_exPC", exPC, 32'h4000 + 32'(i) * 32'h10);
    end
    check("t4_drain_err", err, 0);

    // 5: report with the queue empty
    report(32'h6000, 2'b01, 1'b0, 32'h0, 1'b1);
    check("t5_err", err, 1);
    check("t5_exVld", exVld, 0);
    check("t5_rdVld", rdVld, 0);
    tick();
    tick();
    check("t5_err_sticky", err, 1);

    // 6: async reset while recovering; fall-through pc wraps to zero
    push(32'hFFFF_FFF8, 32'h0000_0100, 1'b1, 1'b1);
    report(32'hFFFF_FFFC, 2'b01, 1'b0, 32'h0, 1'b0);
    check("t6_rdVld", rdVld, 1);
    check("t6_rdPC_wrap", rdPC, 32'h0);
    check("t6_exVld", exVld, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_rdVld", rdVld, 0);
    check("t6_rst_exVld", exVld, 0);
    check("t6_rst_pdRdy", pdRdy, 0);
    check("t6_rst_err", err, 0);
    tick();
    rst = 1'b0;
    #1;
    check("t6_rel_pdRdy", pdRdy, 1);
    push(32'h8000, 32'h8100, 1'b1, 1'b0);
    report(32'h8000, 2'b10, 1'b1, 32'h8100, 1'b1);
    check("t6_post_exVld", exVld, 1);
    check("t6_post_exWrong", exWrong, 0);
    check("t6_post_rdVld", rdVld, 0);
    check("t6_post_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Consumer and checker for the branch predictor's output.
- Records every fetch-packet prediction in an in-order queue, compares each one with the outcome resolved in EX, and produces the predictor training interface (exVld/exPC/exPCTar/exType/exBranch/exWrong).
- On a mispredict it raises a redirect to fetch and holds it until fetch acknowledges.
- Sits between the IF stage, the EX branch unit and the branch predictor.

Parameters:
- ADDR_WIDTH, 32, address width.
- QUEUE_DEPTH, 8, number of in-flight prediction records; power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- pdVld  in  1  fetch packet issued with its prediction
- pdRdy  out  1  queue can accept a record
- pdFetchPC  in  ADDR_WIDTH  pc of the first instruction in the packet
- pdPC  in  ADDR_WIDTH  predicted next pc
- pdBranch  in  1  a taken branch was predicted
- pdReason  in  1  slot (pc[2]) of the predicted branch
- exInVld  in  1  one instruction resolved this cycle
- exInPC  in  ADDR_WIDTH  its pc
- exInType  in  2  type (00 non-branch, 01 cond, 10 direct, 11 indirect)
- exInTaken  in  1  actually taken
- exInTar  in  ADDR_WIDTH  actual target
- exInLast  in  1  last executed instruction of the packet
- exVld, exPC, exPCTar, exType, exBranch, exWrong  out  1/AW/AW/2/1/1  registered training outputs to the predictor
- rdVld  out  1  redirect request
- rdPC  out  ADDR_WIDTH  correct next pc
- rdAck  in  1  fetch accepted the redirect
- err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst=1):
  - queue empty, state RUN, err=0.
  - All ex* outputs and rdVld/rdPC are 0; pdRdy=0 while rst is high.
- Push: on pdVld && pdRdy, write {pdFetchPC, pdPC, pdBranch, pdReason} at the tail.
  - pdRdy = !full && state==RUN.
  - A pop in the same cycle does not free a slot for that cycle's push.
- Check, RUN state only, applied to the head record when exInVld:
  - slot = exInPC[2]; here = head.pdBranch && head.pdReason==slot.
  - wrong = (exInTaken != here) || (exInTaken && here && exInTar != head.pdPC).
  - Non-branch type with here=1 is wrong (not taken).
  - correctPC = exInTaken ? exInTar : exInPC+4, wrapping modulo 2^ADDR_WIDTH.
- Pop: the head is popped on exInVld && (exInLast || wrong).
- Training outputs, latency 1 cycle:
  - On every exInVld in RUN with exInType!=00, the next cycle drives exVld=1, exPC=exInPC, exPCTar=exInTar, exType, exBranch=exInTaken, exWrong=wrong.
  - Otherwise exVld=0 and exWrong=0. Data outputs hold their last value.
- FSM:
  - RUN -> RECOVER on wrong. The entire queue is flushed in that same cycle (including a same-cycle push), rdPC<=correctPC, rdVld<=1 registered.
  - RECOVER: pushes are blocked, exIn* is ignored (no training, no check), rdVld stays 1 and rdPC stays stable.
  - RECOVER -> RUN on rdAck: rdVld is 0 in the next cycle.
  - rdAck in RUN is ignored.
- Empty: exInVld in RUN with an empty queue sets err=1. No pop, no training, no redirect.
- Reset mid-RECOVER returns to RUN with the queue empty and rdVld=0 asynchronously.
- Pointers are QUEUE_DEPTH-bit-wide-log2 plus 1 wrap bit; full/empty are derived from the pointers.

Optional Feature:
- BRANCH_RESOLVE_STAT_EN defined: adds outputs statBranches[31:0] and statWrong[31:0].
  - Both count, in the same cycle as the check, resolved branch-type reports and mispredicts in RUN.
  - Both cleared by rst and saturate at all-ones.
- Not defined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package branch_pkg:
  - Type encodings BR_NONE=2'b00, BR_COND=2'b01, BR_DIRECT=2'b10, BR_INDIRECT=2'b11.
  - Prediction record struct {fetch_pc, pred_pc, branch, reason}.
  - FSM state enum {RUN, RECOVER}.
- One sub-module, pred_queue: a synchronous FIFO with flush, push/pop, head read and full/empty.
- The checker, FSM and output registers stay in branch_resolve.

Test Plan:
1. Correctly predicted taken branch:
   - Push {0x1000, pdPC=0x2000, pdBranch=1, pdReason=1}; report pc 0x1000 non-branch, then pc 0x1004 cond taken tar 0x2000 last.
   - Expect: one cycle later exVld=1, exWrong=0, exBranch=1. Queue empty, rdVld=0.
2. Not-taken mispredicted as taken:
   - Same record; report pc 0x1004 cond not-taken.
   - Expect: exWrong=1, rdVld=1 with rdPC=0x1008. pdRdy=0 until rdAck; RUN and empty on the cycle after rdAck.
3. Target mismatch:
   - Predicted 0x2000; indirect taken to 0x3000.
   - Expect: exWrong=1, rdPC=0x3000, queue flushed.
4. Fill and full:
   - Push 8 records with no reports.
   - Expect: pdRdy=0 and a 9th pdVld is dropped. Report last on record 0 -> pdRdy=1 the next cycle, not the same cycle.
5. Empty report:
   - exInVld with an empty queue.
   - Expect: err=1 and sticky, exVld=0, rdVld=0.
6. Async reset mid-RECOVER:
   - Assert rst while rdVld=1.
   - Expect: rdVld=0 and exVld=0 immediately. After release, the next push is accepted.
